bitslip_deser: RTL
==================

Name: bitslip_deser

Overview:
- Serial-to-parallel word deserializer with bit-slip alignment control.
- Sits directly upstream of the bit-slip generator. Its parallel word output feeds the generator's data_in, and the generator's bsp_gen pulse drives this block's bitslip input.
- Each bitslip request moves the word boundary one bit later in the serial stream. The generator keeps slipping until its training pattern is seen.

Parameters:
- WIDTH, 16, parallel word width in bits. Legal range is 2..16.
- MSB_FIRST, 1, bit order. 1 = first received bit of a word lands in data_out[WIDTH-1]. 0 = first received bit lands in data_out[0].

Ports:
- fclk  input  1  bit clock; one serial bit is sampled per rising edge.
- rst  input  1  asynchronous reset, active-high.
- clr  input  1  synchronous clear of bit counter, slip counter and edge detector; same-cycle priority over all other activity.
- ser_in  input  1  serial data bit, sampled on every fclk edge.
- bitslip  input  1  slip request; one slip per rising edge of this signal.
- data_out  output  WIDTH  last completed parallel word; held between words.
- word_valid  output  1  one-cycle pulse, asserted in the cycle data_out updates.
- slip_cnt  output  5  slips taken modulo WIDTH.

Behaviour:
- Reset (rst high, asynchronous) clears everything to 0: shift register sr, bit_cnt, data_out, word_valid, slip_cnt, bitslip_d.
- Shift register: sr shifts every fclk edge, including slip cycles.
  - MSB_FIRST=1: sr <= {sr[WIDTH-2:0], ser_in}.
  - MSB_FIRST=0: sr <= {ser_in, sr[WIDTH-1:1]}.
- Slip edge detect:
  - bitslip_d <= bitslip every cycle.
  - slip = bitslip & ~bitslip_d.
  - A level held high for N cycles gives exactly one slip.
  - Back-to-back slips need bitslip low for at least one cycle between requests.
- Bit counter: bit_cnt counts 0..WIDTH-1 and wraps to 0.
  - If slip is active, bit_cnt holds its value for that cycle; otherwise it increments.
  - Net effect: every word boundary after the slip falls one bit later.
- Word emit: when bit_cnt==WIDTH-1 and slip==0:
  - data_out <= next value of sr (the word including the current ser_in bit).
  - word_valid <= 1 for that cycle only; otherwise word_valid <= 0.
- Slip at the boundary: if slip coincides with bit_cnt==WIDTH-1, that cycle's emit is suppressed.
  - bit_cnt stays at WIDTH-1.
  - The word is emitted on the next cycle and contains one newer bit.
  - The spacing between word_valid pulses is WIDTH+1 cycles across any single slip.
- Latency and timing:
  - First word_valid occurs on the WIDTH-th fclk edge after rst deassertion; the word holds bits 1..WIDTH.
  - With no slips, word_valid repeats every WIDTH cycles.
- Slip counter:
  - slip_cnt increments on each slip and wraps from WIDTH-1 to 0.
  - WIDTH slips restore the original alignment and show slip_cnt = 0.
- clr:
  - Synchronously zeroes bit_cnt, slip_cnt and bitslip_d.
  - Forces word_valid = 0 that cycle.
  - A slip edge in the same cycle is discarded.
  - sr and data_out are unaffected.
- Reset mid-word: the partial word is discarded. Counting restarts from 0 after release, with no spurious word_valid.
- No other state exists. The block never stalls ser_in, and data_out changes only with word_valid.

Test Plan:
- Aligned stream: WIDTH=16, MSB_FIRST=1, ser_in repeats 0xFF00 MSB-first from the first cycle after reset -> word_valid on edge 16, 32, 48, ...; data_out=0xFF00 each time; slip_cnt=0.
- Misaligned start: three '0' bits, then repeating 0xFF00 -> data_out=0x1FE0 repeatedly.
  - Pulse bitslip once (1 cycle) -> next word 0x3FC0, slip_cnt=1, gap between word_valid pulses = 17 cycles.
  - Two more pulses -> 0x7F80, then 0xFF00; slip_cnt=3.
- Slip on boundary: assert the bitslip rising edge exactly when bit_cnt=15 -> no word_valid that cycle; word_valid the next cycle with data shifted by one bit; slip_cnt increments by 1.
- Held level and wrap:
  - bitslip high for 40 cycles -> exactly one slip.
  - 16 separate pulses -> slip_cnt returns to 0 and data_out returns to the pre-slip value.
- Reset and clear:
  - Assert rst at bit_cnt=7 -> all outputs 0 immediately; first word_valid 16 edges after release.
  - clr together with a slip edge -> slip_cnt=0, no slip taken, next word_valid 16 cycles later.

Source files
------------

// File: rtl/bitslip_deser.sv
// -----------------------------------------------------------------------------
// bitslip_deser
//
// Serial-to-parallel deserializer with bit-slip word alignment. One serial bit
// is shifted in on every fclk rising edge. A rising edge on bitslip holds the
// bit counter for one cycle, so every later word boundary lands one bit later
// in the serial stream. Paired with a bit-slip generator that pulses bitslip
// until its training pattern shows up on data_out.
//
// Parameters:
//   WIDTH      parallel word width, 2..16
//   MSB_FIRST  1: first received bit of a word lands in data_out[WIDTH-1]
//              0: first received bit of a word lands in data_out[0]
//
// Ports:
//   fclk        in   bit clock, one serial bit sampled per rising edge
//   rst         in   asynchronous reset, active-high
//   clr         in   synchronous clear of bit counter, slip counter and slip
//                    edge detector; overrides everything else in that cycle
//   ser_in      in   serial data bit
//   bitslip     in   slip request, one slip per rising edge
//   data_out    out  last completed parallel word, held between words
//   word_valid  out  one-cycle pulse in the cycle data_out updates
//   slip_cnt    out  slips taken, modulo WIDTH
//
// Output handshake: word_valid is a push-only strobe with no ready/back-pressure.
// data_out is valid in any cycle where word_valid is 1 and keeps that value
// until the next word_valid pulse; the consumer must take it in that window.
// -----------------------------------------------------------------------------
module bitslip_deser #(
  parameter int WIDTH     = 16,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             fclk,
  input  logic             rst,
  input  logic             clr,
  input  logic             ser_in,
  input  logic             bitslip,
  output logic [WIDTH-1:0] data_out,
  output logic             word_valid,
  output logic [4:0]       slip_cnt
);

  localparam logic [4:0] LAST = 5'(WIDTH - 1);

  logic [WIDTH-1:0] sr_q, sr_d;
  logic [4:0]       bit_cnt_q, bit_cnt_d;
  logic [4:0]       slip_cnt_q, slip_cnt_d;
  logic             bitslip_q, bitslip_d;
  logic [WIDTH-1:0] data_out_q, data_out_d;
  logic             word_valid_q, word_valid_d;

  logic             slip;
  logic             at_last;

  // A slip edge arriving together with clr is thrown away.
  assign slip    = bitslip & ~bitslip_q & ~clr;
  assign at_last = (bit_cnt_q == LAST);

  // The shift register never stalls, not even on slip or clr cycles; a slip
  // only delays where the counter says the word ends.
  always_comb begin
    sr_d = sr_q;
    if (MSB_FIRST) begin
      sr_d = {sr_q[WIDTH-2:0], ser_in};
    end else begin
      sr_d = {ser_in, sr_q[WIDTH-1:1]};
    end
  end

  always_comb begin
    bitslip_d    = bitslip;
    bit_cnt_d    = bit_cnt_q;
    slip_cnt_d   = slip_cnt_q;
    word_valid_d = 1'b0;
    data_out_d   = data_out_q;
    if (clr) begin
      bitslip_d  = 1'b0;
      bit_cnt_d  = '0;
      slip_cnt_d = '0;
    end else if (slip) begin
      // Holding the counter here also suppresses an emit that would have
      // happened this cycle; the word then comes out next cycle, one bit newer.
      slip_cnt_d = (slip_cnt_q == LAST) ? 5'd0 : slip_cnt_q + 5'd1;
    end else begin
      bit_cnt_d = at_last ? 5'd0 : bit_cnt_q + 5'd1;
      if (at_last) begin
        word_valid_d = 1'b1;
        data_out_d   = sr_d;
      end
    end
  end

  always_ff @(posedge fclk or posedge rst) begin
    if (rst) begin
      sr_q         <= '0;
      bit_cnt_q    <= '0;
      slip_cnt_q   <= '0;
      bitslip_q    <= 1'b0;
      data_out_q   <= '0;
      word_valid_q <= 1'b0;
    end else begin
      sr_q         <= sr_d;
      bit_cnt_q    <= bit_cnt_d;
      slip_cnt_q   <= slip_cnt_d;
      bitslip_q    <= bitslip_d;
      data_out_q   <= data_out_d;
      word_valid_q <= word_valid_d;
    end
  end

  assign data_out   = data_out_q;
  assign word_valid = word_valid_q;
  assign slip_cnt   = slip_cnt_q;

endmodule
